// File: rtl/msrv32_csr_pkg.sv
// MSRV32 machine-mode CSR file: shared address map, operation encodings and
// mstatus bit positions. The user-counter aliases (cycle/instret) are only
// decoded when MSRV32_USER_COUNTERS_EN is defined.
package msrv32_csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // User-mode read-only counter aliases
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // funct3 encodings of the Zicsr instructions; 000/100 never write
    typedef enum logic [2:0] {
        CSR_NONE  = 3'b000,
        CSR_RW    = 3'b001,
        CSR_RS    = 3'b010,
        CSR_RC    = 3'b011,
        CSR_NONEI = 3'b100,
        CSR_RWI   = 3'b101,
        CSR_RSI   = 3'b110,
        CSR_RCI   = 3'b111
    } csr_op_e;

    // mstatus bit positions
    localparam logic [4:0] MSTATUS_MIE  = 5'd3;
    localparam logic [4:0] MSTATUS_MPIE = 5'd7;

endpackage

// File: rtl/msrv32_counter64.sv
// 64-bit event counter with independently writable 32-bit halves.
// A write to either half suppresses that cycle's increment.
module msrv32_counter64 (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wr_data,
    output logic [63:0] count
);

    // Write beats increment; full 64-bit add gives same-cycle carry and wrap
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) count[31:0]  <= wr_data;
            if (wr_hi) count[63:32] <= wr_data;
        end else if (inc_en) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/msrv32_csr_file.sv
// MSRV32 machine-mode CSR file: combinational read of the addressed CSR
// (pre-write value), RW/RS/RC(I) updates, 64-bit mcycle/minstret and trap
// capture of mepc/mcause/mstatus. Define MSRV32_USER_COUNTERS_EN to decode
// the read-only user aliases cycle/cycleh/instret/instreth.
module msrv32_csr_file
    import msrv32_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic [11:0] csr_addr_in,
    input  logic [2:0]  csr_op_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] rs1_in,
    input  logic [4:0]  zimm_in,
    input  logic        instret_inc_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_pc_in,
    input  logic [31:0] trap_cause_in,
    output logic [31:0] csr_data_out,
    output logic        illegal_csr_out,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);

    logic        mie;
    logic        mpie;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] rdata;
    logic        implemented;
    logic [31:0] src;
    logic [31:0] wdata;
    logic        op_valid;
    logic        wr_commit;
    csr_op_e     op;

    assign op = csr_op_e'(csr_op_in);

    // Address decode and read mux; reflects state before any same-cycle write
    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (csr_addr_in)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE]  = mie;
                rdata[MSTATUS_MPIE] = mpie;
            end
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_MHARTID:   rdata = HART_ID;
`ifdef MSRV32_USER_COUNTERS_EN
            CSR_CYCLE:     rdata = mcycle[31:0];
            CSR_CYCLEH:    rdata = mcycle[63:32];
            CSR_INSTRET:   rdata = minstret[31:0];
            CSR_INSTRETH:  rdata = minstret[63:32];
`endif
            default:       implemented = 1'b0;
        endcase
    end

    // Read-modify-write value and the legality of the access
    always_comb begin
        src      = csr_op_in[2] ? {27'b0, zimm_in} : rs1_in;
        wdata    = rdata;
        op_valid = 1'b1;
        case (op)
            CSR_RW, CSR_RWI: wdata = src;
            CSR_RS, CSR_RSI: wdata = rdata | src;
            CSR_RC, CSR_RCI: wdata = rdata & ~src;
            default:         op_valid = 1'b0;
        endcase
        illegal_csr_out = ~implemented | (csr_wr_en_in & (csr_addr_in[11:10] == 2'b11));
        wr_commit       = csr_wr_en_in & op_valid & ~illegal_csr_out;
    end

    // Trap entry owns mepc/mcause/mstatus for its cycle; other CSRs still take writes
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            mie        <= 1'b0;
            mpie       <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            if (trap_taken_in) begin
                mepc_q   <= trap_pc_in & ~32'h3;
                mcause_q <= trap_cause_in;
                mpie     <= mie;
                mie      <= 1'b0;
            end else if (wr_commit) begin
                if (csr_addr_in == CSR_MSTATUS) begin
                    mie  <= wdata[MSTATUS_MIE];
                    mpie <= wdata[MSTATUS_MPIE];
                end
                if (csr_addr_in == CSR_MEPC)   mepc_q   <= wdata & ~32'h3;
                if (csr_addr_in == CSR_MCAUSE) mcause_q <= wdata;
            end
            if (wr_commit && csr_addr_in == CSR_MTVEC)    mtvec_q    <= wdata & ~32'h3;
            if (wr_commit && csr_addr_in == CSR_MSCRATCH) mscratch_q <= wdata;
        end
    end

    msrv32_counter64 u_mcycle (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc_en   (1'b1),
        .wr_lo    (wr_commit && csr_addr_in == CSR_MCYCLE),
        .wr_hi    (wr_commit && csr_addr_in == CSR_MCYCLEH),
        .wr_data  (wdata),
        .count    (mcycle)
    );

    msrv32_counter64 u_minstret (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc_en   (instret_inc_in),
        .wr_lo    (wr_commit && csr_addr_in == CSR_MINSTRET),
        .wr_hi    (wr_commit && csr_addr_in == CSR_MINSTRETH),
        .wr_data  (wdata),
        .count    (minstret)
    );

    assign csr_data_out = rdata;
    assign mtvec_out    = mtvec_q;
    assign mepc_out     = mepc_q;

endmodule

// File: doc/msrv32_csr_file.md
Name: msrv32_csr_file

Overview:
- Machine-mode CSR file for the MSRV32 execute/writeback stage.
- Consumes the csr_* and rs1 fields from the stage-2 pipeline register.
- Returns CSR read data to the writeback mux.
- Maintains 64-bit cycle and instret counters, and records trap state (mepc, mcause) for the PC mux.

Parameters:
HART_ID, 32'd0, value returned by mhartid (0xF14)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec; bits [1:0] ignored

Ports:
clk_in  input  1  clock; all state updates on rising edge
reset_in  input  1  asynchronous, active-high reset
csr_addr_in  input  12  CSR address (registered upstream)
csr_op_in  input  3  funct3 encoding: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
csr_wr_en_in  input  1  write enable; decoder deasserts it for RS/RC(I) when source field is x0
rs1_in  input  32  register source operand
zimm_in  input  5  immediate source, zero-extended for ops 1xx
instret_inc_in  input  1  one instruction retired this cycle
trap_taken_in  input  1  trap entry this cycle
trap_pc_in  input  32  PC of trapping instruction
trap_cause_in  input  32  cause code
csr_data_out  output  32  combinational read of csr_addr_in (pre-write value)
illegal_csr_out  output  1  combinational access-fault flag
mtvec_out  output  32  current mtvec
mepc_out  output  32  current mepc

Behaviour:
- Reset: all CSRs are 0 except mtvec = {MTVEC_RESET[31:2],2'b00}. Outputs follow: csr_data_out is the read of address 0, which is 0 with illegal_csr_out=1.
- Implemented CSRs:
  - mstatus 0x300: only bits 3 (MIE) and 7 (MPIE) are writable; all other bits read 0.
  - mtvec 0x305: bits [1:0] read 0 (direct mode only).
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342.
  - mcycle 0xB00 / mcycleh 0xB80.
  - minstret 0xB02 / minstreth 0xB82.
  - mhartid 0xF14: read-only.
- Read path: csr_data_out is purely combinational from csr_addr_in with zero latency. It returns the value before any same-cycle write. Unimplemented addresses read 0.
- Source operand: src = csr_op_in[2] ? {27'b0,zimm_in} : rs1_in.
- New value:
  - RW: src
  - RS: old | src
  - RC: old & ~src
  - op 000 or 100: no write; illegal_csr_out is not raised by the op.
- Write: committed at the clock edge when csr_wr_en_in=1, the op is valid and illegal_csr_out=0.
- illegal_csr_out=1 when the address is unimplemented, or when csr_wr_en_in=1 and csr_addr_in[11:10]==2'b11 (read-only space). An illegal access suppresses the write.
- Counters:
  - mcycle is a 64-bit counter that increments every cycle.
  - minstret is a 64-bit counter that increments when instret_inc_in=1.
  - A write to a 32-bit half replaces that half and the other half holds. No increment is applied that cycle, so the written value is visible next cycle and increments start from it.
  - Wrap-around: 64'hFFFF_FFFF_FFFF_FFFF increments to 0.
  - Carry from the low half into the high half occurs within the same cycle.
- Trap:
  - trap_taken_in=1 sets mepc <= {trap_pc_in[31:2],2'b00}, mcause <= trap_cause_in, MPIE <= MIE, MIE <= 0.
  - Trap has priority over a same-cycle CSR write to mepc, mcause or mstatus; that write is dropped.
  - Writes to other CSRs in the same cycle proceed.
- Reset mid-operation asynchronously clears all state, including counters. Counting resumes on the first edge after reset deassertion.

Optional Feature:
- Macro MSRV32_USER_COUNTERS_EN.
- Defined: adds read-only aliases cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82 of the machine counters. Any write attempt raises illegal_csr_out, since these addresses sit in the read-only space.
- Undefined: these addresses are unimplemented; a read returns 0 with illegal_csr_out=1.

Decomposition:
- Package msrv32_csr_pkg holds:
  - CSR address localparams.
  - csr_op encodings (CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI).
  - mstatus bit indices MIE=3, MPIE=7.
- Sub-module msrv32_counter64 is instantiated for mcycle and minstret. It has inputs inc_en, wr_lo, wr_hi and wr_data[31:0], and output count[63:0], with write-over-increment priority.

Test Plan:
- Reset release, read 0x305 -> csr_data_out = MTVEC_RESET & ~3. Read 0xF14 -> HART_ID. Read 0x7C0 -> 0 with illegal_csr_out=1.
- Write mscratch with RW 0xA5A5_0F0F; next cycle RS src 0x0000_F000 -> read 0xA5A5_FF0F; then RCI zimm=5'h0F -> read 0xA5A5_FF00.
- Write mcycle low = 0xFFFF_FFFE and mcycleh = 0. After 3 cycles mcycleh = 1 and mcycle = 0x0000_0001; the read in the write cycle shows the old value.
- Write mcycle and mcycleh = 0xFFFF_FFFF in consecutive cycles, then idle 2 cycles -> 64-bit counter wraps through 0 to 1 (fine-tune via the write cycle).
- Set MIE, then same cycle: trap_taken_in with trap_pc_in 0x0000_1236, cause 0xB, plus a CSR RW to mepc of 0x40 -> mepc=0x1234, mcause=0xB, MIE=0, MPIE=1; the 0x40 write is dropped.
- csr_wr_en_in=1, RW to 0xB00 with minstret incrementing -> write wins, minstret increments independently. RW to 0xF14 -> illegal_csr_out=1 and the value is unchanged. Assert reset_in mid-count -> all counters read 0 asynchronously.
